// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: cache configuration types and the PLRU tree path helper
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_MAX_WAYS = 32;

    typedef struct packed {
        int unsigned sets;
        int unsigned ways;
    } hpdcache_user_cfg_t;

    typedef struct packed {
        hpdcache_user_cfg_t u;
    } hpdcache_cfg_t;

    typedef struct packed {
        logic [HPDCACHE_MAX_WAYS-2:0] mask;
        logic [HPDCACHE_MAX_WAYS-2:0] dir;
    } hpdcache_plru_path_t;

    // mask marks the nodes on the root-to-leaf path of way; dir is 1 where the path goes right
    function automatic hpdcache_plru_path_t hpdcache_plru_tree_path(input int unsigned way,
                                                                    input int unsigned ways);
        hpdcache_plru_path_t p;
        int unsigned n;
        p = '0;
        n = way + ways;
        for (int l = 0; l < $clog2(HPDCACHE_MAX_WAYS); l++) begin
            if (n > 1) begin
                p.mask[5'(n / 2 - 1)] = 1'b1;
                p.dir[5'(n / 2 - 1)] = n[0];
                n = n / 2;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hpdcache_plru_tree_walk.sv
// hpdcache_plru_tree_walk: masked pseudo-LRU tree walk returning a one-hot way
module hpdcache_plru_tree_walk #(
    parameter int unsigned W = 4
) (
    input  logic [W-2:0] tree,
    input  logic [W-1:0] mask,
    output logic [W-1:0] way
);

    logic [2*W-1:1] any;
    logic [W-1:1]   go_right;

    // a way wins when every node on its path steers toward it
    always_comb begin
        any = '0;
        any[2*W-1:W] = mask;
        for (int k = W - 1; k >= 1; k--) any[k] = any[2*k] | any[2*k+1];
        go_right = '0;
        for (int k = 1; k < W; k++) go_right[k] = tree[k-1] ? any[2*k+1] : !any[2*k];
        for (int i = 0; i < W; i++) begin
            way[i] = any[1];
            for (int n = i + W; n > 1; n = n / 2) way[i] = way[i] & (go_right[n/2] == n[0]);
        end
    end

endmodule

// File: rtl/hpdcache_prio_1hot_encoder.sv
// hpdcache_prio_1hot_encoder: keeps only the lowest set bit of the input
module hpdcache_prio_1hot_encoder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] val_i,
    output logic [N-1:0] val_o
);

    assign val_o = val_i & (~val_i + N'(1));

endmodule

// File: rtl/hpdcache_victim_tree_plru.sv
// hpdcache_victim_tree_plru: tree-PLRU victim selector; define HPDCACHE_VICTIM_CLEAN_FIRST_EN to prefer clean lines
module hpdcache_victim_tree_plru
    import hpdcache_pkg::*;
#(
    parameter hpdcache_cfg_t HPDcacheCfg = '{u: '{sets: 32'd4, ways: 32'd4}}
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  updt_i,
    input  logic [$clog2(HPDcacheCfg.u.sets)-1:0] updt_set_i,
    input  logic [HPDcacheCfg.u.ways-1:0]         updt_way_i,
    input  logic                                  inv_i,
    input  logic [$clog2(HPDcacheCfg.u.sets)-1:0] inv_set_i,
    input  logic [HPDcacheCfg.u.ways-1:0]         inv_way_i,
    input  logic                                  sel_victim_i,
    input  logic [$clog2(HPDcacheCfg.u.sets)-1:0] sel_victim_set_i,
    input  logic [HPDcacheCfg.u.ways-1:0]         sel_dir_valid_i,
    input  logic [HPDcacheCfg.u.ways-1:0]         sel_dir_dirty_i,
    input  logic [HPDcacheCfg.u.ways-1:0]         sel_dir_fetch_i,
    output logic [HPDcacheCfg.u.ways-1:0]         sel_victim_way_o
);

    localparam int unsigned S = HPDcacheCfg.u.sets;
    localparam int unsigned W = HPDcacheCfg.u.ways;
    localparam int unsigned SET_W = $clog2(S);
    localparam int unsigned TREE_BITS = W - 1;

    typedef logic [TREE_BITS-1:0] tree_t;

    if (W < 2 || (W & (W - 1)) != 0) begin : g_bad_ways
        $error("HPDcacheCfg.u.ways must be a power of two >= 2");
    end

    function automatic int unsigned idx_of(input logic [W-1:0] oh);
        idx_of = 0;
        for (int i = 0; i < W; i++) if (oh[i]) idx_of = i;
    endfunction

    tree_t               tree_q [S];
    tree_t               tree_d [S];
    logic [S-1:0]        inv_hit, sel_hit, updt_hit;
    logic [W-1:0]        cand, unused, elig, walk_mask, unused_oh, walk_oh, victim;
    hpdcache_plru_path_t inv_p, sel_p, updt_p;
    tree_t               inv_m, inv_d, sel_m, sel_d, updt_m, updt_d;
    logic                unused_path;

    assign cand   = ~sel_dir_fetch_i;
    assign unused = cand & ~sel_dir_valid_i;
    assign elig   = cand & sel_dir_valid_i;

`ifdef HPDCACHE_VICTIM_CLEAN_FIRST_EN
    assign walk_mask = |(elig & ~sel_dir_dirty_i) ? elig & ~sel_dir_dirty_i : elig;
`else
    logic unused_dirty;
    assign unused_dirty = ^sel_dir_dirty_i;
    assign walk_mask = elig;
`endif

    hpdcache_prio_1hot_encoder #(.N(W)) unused_enc (
        .val_i (unused),
        .val_o (unused_oh)
    );

    hpdcache_plru_tree_walk #(.W(W)) walk (
        .tree (tree_q[sel_victim_set_i]),
        .mask (walk_mask),
        .way  (walk_oh)
    );

    assign victim = |unused ? unused_oh : walk_oh;
    assign sel_victim_way_o = victim;

    assign inv_p  = hpdcache_plru_tree_path(idx_of(inv_way_i), W);
    assign sel_p  = hpdcache_plru_tree_path(idx_of(victim), W);
    assign updt_p = hpdcache_plru_tree_path(idx_of(updt_way_i), W);
    assign inv_m  = inv_p.mask[TREE_BITS-1:0];
    assign inv_d  = inv_p.dir[TREE_BITS-1:0];
    assign sel_m  = sel_p.mask[TREE_BITS-1:0];
    assign sel_d  = sel_p.dir[TREE_BITS-1:0];
    assign updt_m = updt_p.mask[TREE_BITS-1:0];
    assign updt_d = updt_p.dir[TREE_BITS-1:0];
    assign unused_path = ^{inv_p, sel_p, updt_p};

    // later updates overwrite earlier ones on shared path nodes
    always_comb begin
        for (int s = 0; s < S; s++) begin
            inv_hit[s]  = inv_i && inv_set_i == SET_W'(s);
            sel_hit[s]  = sel_victim_i && |victim && sel_victim_set_i == SET_W'(s);
            updt_hit[s] = updt_i && updt_set_i == SET_W'(s);
            tree_d[s] = inv_hit[s] ? (tree_q[s] & ~inv_m) | (inv_d & inv_m) : tree_q[s];
            tree_d[s] = sel_hit[s] ? (tree_d[s] & ~sel_m) | (~sel_d & sel_m) : tree_d[s];
            tree_d[s] = updt_hit[s] ? (tree_d[s] & ~updt_m) | (~updt_d & updt_m) : tree_d[s];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < S; s++) tree_q[s] <= '0;
        end else begin
            for (int s = 0; s < S; s++) if (inv_hit[s] || sel_hit[s] || updt_hit[s]) tree_q[s] <= tree_d[s];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && updt_i) assert ($onehot(updt_way_i)) else $error("updt_way_i is not one-hot");
        if (rst_ni && inv_i) assert ($onehot(inv_way_i)) else $error("inv_way_i is not one-hot");
    end

endmodule

// File: tb/tb_hpdcache_victim_tree_plru.sv
// tb_hpdcache_victim_tree_plru: directed vectors checked against a way-range PLRU model
module tb_hpdcache_victim_tree_plru;
    import hpdcache_pkg::*;

    localparam int W = 4;
    localparam int S = 4;
    localparam hpdcache_cfg_t CFG = '{u: '{sets: 32'd4, ways: 32'd4}};

    logic       clk = 0;
    logic       rst_ni = 0;
    logic       updt_i = 0, inv_i = 0, sel_victim_i = 0;
    logic [1:0] updt_set_i = 0, inv_set_i = 0, sel_victim_set_i = 0;
    logic [3:0] updt_way_i = 0, inv_way_i = 0;
    logic [3:0] valid = 4'hf, dirty = 0, fetch = 0;
    logic [3:0] victim;
    logic [3:0] rot_exp [5] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
    logic [3:0] clean_exp;
    int         tests = 0, fails = 0;
    bit         mdir [S][2][2];

    always #5 clk = ~clk;

    hpdcache_victim_tree_plru #(.HPDcacheCfg(CFG)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .updt_i           (updt_i),
        .updt_set_i       (updt_set_i),
        .updt_way_i       (updt_way_i),
        .inv_i            (inv_i),
        .inv_set_i        (inv_set_i),
        .inv_way_i        (inv_way_i),
        .sel_victim_i     (sel_victim_i),
        .sel_victim_set_i (sel_victim_set_i),
        .sel_dir_valid_i  (valid),
        .sel_dir_dirty_i  (dirty),
        .sel_dir_fetch_i  (fetch),
        .sel_victim_way_o (victim)
    );

    function automatic bit has(input logic [3:0] m, input int lo, input int n);
        bit r = 0;
        for (int i = lo; i < lo + n; i++) r |= m[i];
        return r;
    endfunction

    // model keeps one direction bit per way range: mdir[set][level][range index]
    function automatic logic [3:0] model_walk(input int s, input logic [3:0] m);
        int lo = 0;
        bit right;
        if (m == 0) return 4'b0;
        for (int lvl = 0; lvl < 2; lvl++) begin
            int size = W >> lvl;
            int half = size / 2;
            right = mdir[s][lvl][lo/size];
            if (right && !has(m, lo + half, half)) right = 0;
            else if (!right && !has(m, lo, half)) right = 1;
            if (right) lo += half;
        end
        return 4'b1 << lo;
    endfunction

    function automatic logic [3:0] model_victim(input int s, input logic [3:0] v, input logic [3:0] f);
        logic [3:0] unused, elig, m;
        unused = ~f & ~v;
        elig = ~f & v;
        for (int i = 0; i < W; i++) if (unused[i]) return 4'b1 << i;
        m = elig;
`ifdef HPDCACHE_VICTIM_CLEAN_FIRST_EN
        if ((elig & ~dirty) != 0) m = elig & ~dirty;
`endif
        return model_walk(s, m);
    endfunction

    task automatic model_path(input int s, input logic [3:0] oh, input bit toward);
        int w = 0;
        int lo = 0;
        for (int i = 0; i < W; i++) if (oh[i]) w = i;
        for (int lvl = 0; lvl < 2; lvl++) begin
            int size = W >> lvl;
            int half = size / 2;
            bit right = (w >= lo + half);
            mdir[s][lvl][lo/size] = toward ? right : !right;
            if (right) lo += half;
        end
    endtask

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < S; s++)
                for (int l = 0; l < 2; l++)
                    for (int p = 0; p < 2; p++) mdir[s][l][p] = 0;
        end else begin
            logic [3:0] v;
            v = model_victim(sel_victim_set_i, valid, fetch);
            if (inv_i) model_path(inv_set_i, inv_way_i, 1);
            if (sel_victim_i && v != 0) model_path(sel_victim_set_i, v, 0);
            if (updt_i) model_path(updt_set_i, updt_way_i, 0);
        end
    end

    always @(negedge clk) begin
        if (rst_ni) begin
            logic [3:0] e;
            e = model_victim(sel_victim_set_i, valid, fetch);
            tests++;
            if (victim !== e) begin
                fails++;
                $display("FAIL cycle victim set %0d: got %b expected %b at %0t", sel_victim_set_i, victim, e, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;
        sel_victim_set_i = 2;
        @(negedge clk);
        chk("reset victim", victim, 4'b0001);
        chk("reset tree", {1'b0, dut.tree_q[2]}, 4'b0000);
        go();
        sel_victim_i = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rotation %0d", k), victim, rot_exp[k]);
            if (k < 4) go();
        end
        go();
        sel_victim_i = 0;
        updt_i = 1;
        updt_set_i = 2;
        updt_way_i = 4'b0001;
        @(negedge clk);
        chk("pre-reset victim", victim, 4'b0100);
        #2 rst_ni = 0;
        #1 chk("async reset victim", victim, 4'b0001);
        go();
        rst_ni = 1;
        updt_i = 0;
        @(negedge clk);
        chk("updt dropped in reset", victim, 4'b0001);
        go();
        sel_victim_set_i = 1;
        valid = 4'b1011;
        @(negedge clk);
        chk("unused priority", victim, 4'b0100);
        go();
        fetch = 4'b0100;
        @(negedge clk);
        chk("unused but fetching", victim, 4'b0001);
        go();
        sel_victim_set_i = 0;
        valid = 4'hf;
        fetch = 4'b0001;
        @(negedge clk);
        chk("fetch mask", victim, 4'b0010);
        go();
        fetch = 4'hf;
        sel_victim_i = 1;
        @(negedge clk);
        chk("all fetching", victim, 4'b0000);
        go();
        sel_victim_i = 0;
        fetch = 0;
        @(negedge clk);
        chk("no touch without victim", {1'b0, dut.tree_q[0]}, 4'b0000);
        chk("victim after empty select", victim, 4'b0001);
        go();
        sel_victim_set_i = 3;
        sel_victim_i = 1;
        inv_i = 1;
        inv_set_i = 3;
        inv_way_i = 4'b1000;
        updt_i = 1;
        updt_set_i = 3;
        updt_way_i = 4'b0010;
        @(negedge clk);
        chk("priority select", victim, 4'b0001);
        go();
        sel_victim_i = 0;
        inv_i = 0;
        updt_i = 0;
        @(negedge clk);
        chk("priority dut nodes", {1'b0, dut.tree_q[3]}, 4'b0101);
        chk("priority model nodes", {1'b0, 1'(mdir[3][1][1]), 1'(mdir[3][1][0]), 1'(mdir[3][0][0])}, 4'b0101);
        chk("priority next lookup", victim, 4'b1000);
        go();
        sel_victim_set_i = 1;
        valid = 4'hf;
        dirty = 4'b0111;
`ifdef HPDCACHE_VICTIM_CLEAN_FIRST_EN
        clean_exp = 4'b1000;
`else
        clean_exp = 4'b0001;
`endif
        @(negedge clk);
        chk("clean first", victim, clean_exp);
        for (int c = 0; c < 80; c++) begin
            go();
            updt_i = 1'($urandom_range(0, 1));
            updt_set_i = 2'($urandom_range(0, 3));
            updt_way_i = 4'b1 << $urandom_range(0, 3);
            inv_i = ($urandom_range(0, 3) == 0);
            inv_set_i = 2'($urandom_range(0, 3));
            inv_way_i = 4'b1 << $urandom_range(0, 3);
            sel_victim_i = 1'($urandom_range(0, 1));
            sel_victim_set_i = 2'($urandom_range(0, 3));
            valid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
            fetch = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            dirty = 4'($urandom_range(0, 15));
        end
        go();
        updt_i = 0;
        inv_i = 0;
        sel_victim_i = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hpdcache_victim_tree_plru.md
# hpdcache_victim_tree_plru

- Tree pseudo-LRU victim selector for the HPDcache miss/refill path.
- Per-set state: W-1 tree bits.
- Walk skips ways that are fetching or not eligible.
- Selecting a victim advances the tree, so back-to-back refills to one set rotate through all ways.
- An invalidation hint steers the tree back toward freed ways.

## Interface
- HPDcacheCfg, '0, cache config; uses u.sets (S) and u.ways (W). W is a power of two ≥ 2, checked by an elaboration assertion.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- updt_i  in  1  access touch on a hit or refill
- updt_set_i  in  log2(S)  touched set
- updt_way_i  in  W  one-hot touched way
- inv_i  in  1  invalidation hint
- inv_set_i  in  log2(S)  invalidated set
- inv_way_i  in  W  one-hot invalidated way
- sel_victim_i  in  1  victim selection is consumed this cycle (commit)
- sel_victim_set_i  in  log2(S)  lookup set
- sel_dir_valid_i / sel_dir_dirty_i / sel_dir_fetch_i  in  W each  directory state of the lookup set
- sel_victim_way_o  out  W  one-hot victim, or '0 when no way is eligible

## Operation
- **State:** tree_q[S][W-1], heap-indexed.
  - Node n is in 1..W-1, stored at bit n-1.
  - Children of node n are 2n and 2n+1. Leaf index n ≥ W means way n-W.
  - Bit = 0 points the victim to the left (lower) subtree; bit = 1 points it right.
- **Candidates:**
  - cand = ~fetch.
  - unused = cand & ~valid.
  - elig = cand & valid.
- **Selection priority:**
  1. If unused ≠ 0, the victim is the lowest-index unused way.
  2. Otherwise, if elig ≠ 0, masked tree walk from the root. At each node, follow the bit direction if that subtree contains an elig way; otherwise take the other direction.
  3. Otherwise the output is '0.
- **Path update:** touch(set, w) sets every node on w's root-to-leaf path to point away from w. point(set, w) sets every node on the path to point toward w.
- **State update per cycle**, in increasing priority (later wins on shared nodes):
  1. If inv_i: point(inv_set_i, inv_way_i).
  2. If sel_victim_i and sel_victim_way_o ≠ 0: touch(sel_victim_set_i, sel_victim_way_o).
  3. If updt_i: touch(updt_set_i, updt_way_i).
- Operations on different sets apply independently in the same cycle.
- A zero or multi-hot updt_way_i / inv_way_i is illegal; guard it with a simulation assertion. The resulting state is don't-care.

## Timing
- sel_victim_way_o is combinational from sel_* inputs and tree_q, valid in the same cycle; there is no handshake latency.
- All state updates take effect on the next rising clk_i edge. A lookup in the same cycle as an update sees the pre-update tree.
- **Reset:** all tree_q bits 0. With all ways valid and not fetching, the output is way 0 (one-hot 0001 for W=4).
- Reset asserted mid-operation clears the state immediately (asynchronous). Updates presented during reset are dropped.
- Only rows touched by an enable (updt_i, inv_i, sel_victim_i) are written; idle cycles hold the state.

## Configuration
- **HPDCACHE_VICTIM_CLEAN_FIRST_EN defined:**
  - In step 2, if elig & ~dirty ≠ 0, the walk mask is elig & ~dirty.
  - Otherwise the mask is elig.
  - Clean lines are preferred over the tree order, avoiding writebacks.
- **Undefined:** the walk mask is elig; dirty state is ignored.
- Step 1 and all update rules are identical in both builds.

## Structure
- **hpdcache_pkg:** add the function hpdcache_plru_tree_path(w), returning the node mask and direction bits for way w. It is shared by touch and point.
- **Local:** localparam TREE_BITS = W-1, and the tree typedef logic [TREE_BITS-1:0].
- **Sub-module:** hpdcache_plru_tree_walk, combinational. Inputs are the tree bits and the eligible mask; output is the one-hot way. It is instantiated once.
- The unused-way choice reuses hpdcache_prio_1hot_encoder.

## Test plan
All scenarios use W=4, S=4.
- **Reset rotation:** after reset, set 2 all valid, nothing fetching, sel_victim_i held for 4 cycles. Victims must be 0001, 0100, 0010, 1000, then repeat from 0001.
- **Unused priority:** valid = 1011, fetch = 0 → victim 0100. Set valid = 1011 and fetch = 0100 (way 2 both invalid and fetching) → the tree walk returns way 0.
- **Fetch masking:** reset state, all valid, fetch = 0001 → victim 0010. With fetch = 1111 → victim 0000, and sel_victim_i does not change tree_q.
- **Priority:** same cycle, same set: inv of way 3, sel touch of victim way 0, and updt of way 1.
  - Resulting nodes must be n1 = 1, n2 = 0, n3 = 1.
  - The next lookup returns way 3.
- **Clean-first (macro on):** reset state, all valid, dirty = 0111 → victim 1000. With the macro off → victim 0001.
- **Async reset mid-run:** after the rotation test, pulse rst_ni low between clock edges. The output must return to 0001 immediately, and a pending updt_i in that cycle must have no effect.
